// File: rtl/controlador_multiplicador.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | controlador_multiplicador                                                  |
// | Two-port arbiter and sequencer for the shared 8x8 unsigned multiplier.     |
// | Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin instead of fixed). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module controlador_multiplicador #(
    parameter int CALC_CYCLES = 1  // legal range 1..4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_p,
    output logic        res_id,
    output logic        busy
);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        CALC   = 2'd1,
        PRONTO = 2'd2
    } state_t;

    localparam logic [1:0] SETTLE_LOAD = 2'(CALC_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        op_id;
    logic [1:0]  settle_cnt;
    logic        grant_valid;
    logic        grant_id;
    logic        accept;
    logic [15:0] product;

    assign product = {8'd0, op_a} * {8'd0, op_b};

`ifdef ARB_ROUND_ROBIN_EN
    logic prio;  // 1 favours requester 1 when both are valid

    always_comb begin
        grant_id = !req0_valid;
        if (req0_valid && req1_valid) begin
            grant_id = prio;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (accept) begin
            prio <= !grant_id;
        end
    end
`else
    always_comb begin
        grant_id = !req0_valid;
    end
`endif

    assign grant_valid = req0_valid || req1_valid;
    assign accept      = (state == OCIOSO) && grant_valid;
    assign req0_ready  = accept && !grant_id;
    assign req1_ready  = accept && grant_id;
    assign busy        = (state != OCIOSO);

    always_comb begin
        state_next = state;
        case (state)
            OCIOSO: if (accept) state_next = CALC;
            CALC:   if (settle_cnt == 2'd0) state_next = PRONTO;
            PRONTO: if (res_ready) state_next = OCIOSO;
            default: state_next = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= OCIOSO;
        end else begin
            state <= state_next;
        end
    end

    // Operands are sampled only on the grant edge so later input changes cannot leak in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a       <= 8'd0;
            op_b       <= 8'd0;
            op_id      <= 1'b0;
            settle_cnt <= 2'd0;
        end else if (accept) begin
            op_a       <= grant_id ? req1_a : req0_a;
            op_b       <= grant_id ? req1_b : req0_b;
            op_id      <= grant_id;
            settle_cnt <= SETTLE_LOAD;
        end else if (state == CALC && settle_cnt != 2'd0) begin
            settle_cnt <= settle_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_p     <= 16'h0000;
            res_id    <= 1'b0;
        end else if (state == CALC && settle_cnt == 2'd0) begin
            res_valid <= 1'b1;
            res_p     <= product;
            res_id    <= op_id;
        end else if (state == PRONTO && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_controlador_multiplicador.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_controlador_multiplicador                                               |
// | Self-checking bench: transaction model, vector table, corner sequences.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_controlador_multiplicador;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam int C = 1;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        res_valid, res_ready, res_id, busy;
    logic [15:0] res_p;

    logic        rst4, v4, rdy4, r1v4, r1rdy4, rv4, rr4, id4, busy4;
    logic [7:0]  a4, b4, r1a4, r1b4;
    logic [15:0] p4;

    int tests = 0;
    int fails = 0;

    controlador_multiplicador #(.CALC_CYCLES(C)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_p(res_p), .res_id(res_id),
        .busy(busy)
    );

    controlador_multiplicador #(.CALC_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst4),
        .req0_valid(v4), .req0_ready(rdy4), .req0_a(a4), .req0_b(b4),
        .req1_valid(r1v4), .req1_ready(r1rdy4), .req1_a(r1a4), .req1_b(r1b4),
        .res_valid(rv4), .res_ready(rr4), .res_p(p4), .res_id(id4),
        .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level reference: one job in flight, result ready C edges after accept.
    bit          m_inflight, m_have, m_pref, m_pid, m_id;
    int          m_left, m_pa, m_pb, m_p;
    bit          hold0, hold1;
    logic [16:0] got[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        bit         id;
        int         exp_p;
    } vec_t;
    vec_t vecs[6];

    function automatic void chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        m_inflight = 0; m_have = 0; m_pref = 0; m_pid = 0; m_id = 0;
        m_left = 0; m_pa = 0; m_pb = 0; m_p = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; res_ready = 1;
        hold0 = 0; hold1 = 0;
        @(posedge clk); #1;
        model_reset();
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_p", int'(res_p), 0);
        chk("rst_res_id", int'(res_id), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
    endtask

    task automatic tick(output int g);
        bit idle;
        int pa, pb;
        #1;
        idle = !m_inflight && !m_have;
        g = -1;
        if (idle) begin
            if (req0_valid && req1_valid) g = (RR && m_pref) ? 1 : 0;
            else if (req0_valid) g = 0;
            else if (req1_valid) g = 1;
        end
        chk("req0_ready", int'(req0_ready), int'(g == 0));
        chk("req1_ready", int'(req1_ready), int'(g == 1));
        if (res_valid && res_ready) got.push_back({res_id, res_p});
        pa = (g == 1) ? int'(req1_a) : int'(req0_a);
        pb = (g == 1) ? int'(req1_b) : int'(req0_b);
        @(posedge clk);
        if (m_have) begin
            if (res_ready) m_have = 0;
        end else if (m_inflight) begin
            m_left--;
            if (m_left == 0) begin
                m_inflight = 0; m_have = 1; m_p = m_pa * m_pb; m_id = m_pid;
            end
        end else if (g >= 0) begin
            m_inflight = 1; m_left = C; m_pa = pa; m_pb = pb;
            m_pid = (g == 1); m_pref = (g == 0);
        end
        #1;
        chk("res_valid", int'(res_valid), int'(m_have));
        chk("res_p", int'(res_p), m_p);
        chk("res_id", int'(res_id), int'(m_id));
        chk("busy", int'(busy), int'(m_inflight || m_have));
        if (g == 0 && !hold0) begin
            req0_valid = 0; req0_a = 8'($urandom); req0_b = 8'($urandom);
        end
        if (g == 1 && !hold1) begin
            req1_valid = 0; req1_a = 8'($urandom); req1_b = 8'($urandom);
        end
    endtask

    task automatic drain();
        int g;
        hold0 = 0; hold1 = 0; res_ready = 1;
        for (int t = 0; t < 50 && (busy || req0_valid || req1_valid); t++) tick(g);
        chk("drain_idle", int'(busy || req0_valid || req1_valid), 0);
    endtask

    initial begin
        int g, n0, acc_at, lat, cnt;
        logic [16:0] e;
        logic [15:0] held_p;
        int exp_ids[4];

        vecs[0] = '{8'd200, 8'd255, 1'b0, 51000};
        vecs[1] = '{8'd255, 8'd255, 1'b1, 65025};
        vecs[2] = '{8'd0,   8'd173, 1'b1, 0};
        vecs[3] = '{8'd1,   8'd128, 1'b1, 128};
        vecs[4] = '{8'd255, 8'd255, 1'b0, 65025};
        vecs[5] = '{8'd16,  8'd16,  1'b1, 256};

        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        rst4 = 1; v4 = 0; a4 = 0; b4 = 0; r1v4 = 0; r1a4 = 0; r1b4 = 0; rr4 = 1;
        do_reset();

        // Single requests from the table; latency must be exactly one edge.
        foreach (vecs[k]) begin
            if (vecs[k].id) begin req1_valid = 1; req1_a = vecs[k].a; req1_b = vecs[k].b; end
            else begin req0_valid = 1; req0_a = vecs[k].a; req0_b = vecs[k].b; end
            n0 = got.size(); acc_at = -1; lat = -1;
            for (int t = 0; t < 30 && got.size() == n0; t++) begin
                tick(g);
                if (res_valid && acc_at >= 0 && lat < 0) lat = t - acc_at;
                if (g >= 0) acc_at = t;
            end
            chk("vec_done", int'(got.size() > n0), 1);
            if (got.size() > n0) begin
                e = got[got.size() - 1];
                chk("vec_p", int'(e[15:0]), vecs[k].exp_p);
                chk("vec_id", int'(e[16]), int'(vecs[k].id));
            end
            chk("vec_latency", lat, 1);
        end

        // Contention: both requesters keep re-issuing.
        do_reset();
        hold0 = 1; hold1 = 1;
        req0_valid = 1; req0_a = 12; req0_b = 11;
        req1_valid = 1; req1_a = 7;  req1_b = 9;
        n0 = got.size();
        for (int t = 0; t < 60 && got.size() < n0 + 4; t++) tick(g);
        chk("cont_count", int'(got.size() >= n0 + 4), 1);
        exp_ids = RR ? '{0, 1, 0, 1} : '{0, 0, 0, 0};
        for (int i = 0; i < 4 && n0 + i < got.size(); i++) begin
            e = got[n0 + i];
            chk("cont_id", int'(e[16]), exp_ids[i]);
            chk("cont_p", int'(e[15:0]), exp_ids[i] == 1 ? 63 : 132);
        end
        hold0 = 0; req0_valid = 0;
        n0 = got.size();
        for (int t = 0; t < 30 && got.size() == n0; t++) tick(g);
        chk("after_drop_done", int'(got.size() > n0), 1);
        if (got.size() > n0) begin
            e = got[got.size() - 1];
            chk("after_drop_id", int'(e[16]), 1);
            chk("after_drop_p", int'(e[15:0]), 63);
        end
        hold1 = 0; req1_valid = 0;
        drain();

        // Backpressure with a pending request from requester 1.
        req0_valid = 1; req0_a = 5; req0_b = 6;
        for (int t = 0; t < 20 && !m_have; t++) tick(g);
        chk("bp_have_result", int'(res_valid), 1);
        res_ready = 0;
        req1_valid = 1; req1_a = 3; req1_b = 4;
        held_p = res_p;
        for (int t = 0; t < 5; t++) begin
            tick(g);
            chk("bp_stall_p", int'(res_p), 30);
            chk("bp_stall_valid", int'(res_valid), 1);
        end
        chk("bp_held", int'(held_p), 30);
        res_ready = 1;
        tick(g);
        chk("bp_release_no_grant", g, -1);
        tick(g);
        chk("bp_next_grant", g, 1);
        drain();

        // Randomised traffic against the model.
        for (int t = 0; t < 400; t++) begin
            if (!req0_valid && $urandom_range(2) == 0) begin
                req0_valid = 1; req0_a = 8'($urandom); req0_b = 8'($urandom);
            end else if (req0_valid && $urandom_range(15) == 0) req0_valid = 0;
            if (!req1_valid && $urandom_range(2) == 0) begin
                req1_valid = 1; req1_a = 8'($urandom); req1_b = 8'($urandom);
            end else if (req1_valid && $urandom_range(15) == 0) req1_valid = 0;
            res_ready = ($urandom_range(3) != 0);
            tick(g);
        end
        drain();

        // Reset in the middle of a CALC_CYCLES=4 operation.
        @(posedge clk); #1;
        rst4 = 0; v4 = 1; a4 = 9; b4 = 7;
        cnt = 0;
        while (!rdy4 && cnt < 10) begin @(posedge clk); #1; cnt++; end
        @(posedge clk); #1;
        v4 = 0; a4 = 8'hFF;
        for (int t = 0; t < 10 && !rv4; t++) begin @(posedge clk); #1; end
        chk("r4_first_p", int'(p4), 63);
        @(posedge clk); #1;
        v4 = 1; a4 = 200; b4 = 3;
        #1 chk("r4_ready", int'(rdy4), 1);
        @(posedge clk); #1;
        v4 = 0;
        @(posedge clk); @(posedge clk); #2;
        rst4 = 1;
        #1;
        chk("r4_async_valid", int'(rv4), 0);
        chk("r4_async_p", int'(p4), 0);
        chk("r4_async_busy", int'(busy4), 0);
        @(posedge clk); #1;
        rst4 = 0;
        cnt = 0;
        for (int t = 0; t < 8; t++) begin @(posedge clk); #1; if (rv4) cnt++; end
        chk("r4_no_stale_result", cnt, 0);
        v4 = 1; a4 = 13; b4 = 17;
        #1 chk("r4_new_ready", int'(rdy4), 1);
        @(posedge clk); #1;
        v4 = 0;
        lat = 0;
        while (!rv4 && lat < 12) begin @(posedge clk); #1; lat++; end
        chk("r4_latency", lat, 4);
        chk("r4_new_p", int'(p4), 221);
        chk("r4_new_id", int'(id4), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
